sdp_ram_pipelined: RTL and testbench

//  Simple dual-port RAM (one write port, one read port) with independent write/read pipeline latency.

---
 rtl/sdp_ram_pkg.sv | 11 +
 rtl/pipe_delay.sv | 29 ++
 rtl/sdp_ram_pipelined.sv | 124 ++++++++++++
 tb/tb_sdp_ram_pipelined.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared constants and helpers for the pipelined simple dual-port RAM.
package sdp_ram_pkg;

  localparam int MIN_WR_LATENCY = 1;
  localparam int MIN_RD_LATENCY = 1;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-cleared shift register of DEPTH stages; DEPTH=0 is a wire.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/sdp_ram_pipelined.sv
// Simple dual-port RAM with byte enables, independent write/read latency and
// optional forwarding of in-flight writes into reads.
module sdp_ram_pipelined
  import sdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int WR_LATENCY = 3,
  parameter int RD_LATENCY = 2,
  parameter bit BYPASS     = 1'b1,
  localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_BYTES-1:0]  write_byte_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int WSTAGES = WR_LATENCY - 1;
  localparam int WS_DIM  = (WSTAGES > 0) ? WSTAGES : 1;

  if (WR_LATENCY < MIN_WR_LATENCY) begin : g_bad_wr
    $error("sdp_ram_pipelined: WR_LATENCY must be >= 1");
  end
  if (RD_LATENCY < MIN_RD_LATENCY) begin : g_bad_rd
    $error("sdp_ram_pipelined: RD_LATENCY must be >= 1");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $error("sdp_ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_BYTES-1:0]  byte_en;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wr_req_t               wr_req, wr_commit;
  wr_req_t [WS_DIM-1:0]  wr_stage;  // [0] youngest, [WSTAGES-1] oldest

  assign wr_req = '{valid: write_enable, addr: write_addr,
                    byte_en: write_byte_en, data: data_in};

  // Write pipeline as a chain of single-stage delays so every pending
  // request is visible to the forwarding compare.
  if (WSTAGES == 0) begin : g_wr_direct
    assign wr_stage  = '0;
    assign wr_commit = wr_req;
  end else begin : g_wr_pipe
    for (genvar s = 0; s < WSTAGES; s++) begin : g_stage
      pipe_delay #(.WIDTH($bits(wr_req_t)), .DEPTH(1)) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ((s == 0) ? wr_req : wr_stage[(s == 0) ? 0 : s-1]),
        .dout (wr_stage[s])
      );
    end
    assign wr_commit = wr_stage[WSTAGES-1];
  end

  // rst_n gate keeps a latency-1 write sampled during reset from committing.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit.valid) begin
      for (int b = 0; b < NUM_BYTES; b++)
        if (wr_commit.byte_en[b])
          mem[wr_commit.addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_commit.data[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] rd_fwd;
  logic [DATA_WIDTH-1:0]                rd_word;

  assign rd_word = mem[read_addr];

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane;

    // Oldest to youngest, so the youngest matching pending write wins.
    always_comb begin
      lane = rd_word[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (BYPASS) begin
        for (int s = WSTAGES - 1; s >= 0; s--)
          if (wr_stage[s].valid && wr_stage[s].byte_en[b] && wr_stage[s].addr == read_addr)
            lane = wr_stage[s].data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign rd_fwd[b] = lane;
  end

  // First read stage holds its data across bubbles, so the delayed copy
  // presented on data_out keeps the last valid value during gaps.
  logic                  rd_vld0;
  logic [DATA_WIDTH-1:0] rd_data0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld0  <= 1'b0;
      rd_data0 <= '0;
    end else begin
      rd_vld0 <= read_enable;
      if (read_enable) rd_data0 <= rd_fwd;
    end
  end

  pipe_delay #(.WIDTH(DATA_WIDTH + 1), .DEPTH(RD_LATENCY - 1)) u_rd_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({rd_vld0, rd_data0}),
    .dout ({read_valid, data_out})
  );

endmodule

// File: tb/tb_sdp_ram_pipelined.sv
// Directed bench: BYPASS=1 and BYPASS=0 instances share stimulus; a write-history
// model fills per-instance scoreboards that are checked every cycle.
module tb_sdp_ram_pipelined;

  localparam int WL = 3;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [3:0]  wa = '0, ra = '0, be = '0;
  logic [31:0] din = '0;
  logic [31:0] dout1, dout0;
  logic        vld1, vld0;

  always #5 clk = ~clk;

  sdp_ram_pipelined #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                      .WR_LATENCY(WL), .RD_LATENCY(RL), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_addr(wa), .write_byte_en(be),
    .data_in(din), .read_enable(re), .read_addr(ra), .data_out(dout1), .read_valid(vld1));

  sdp_ram_pipelined #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                      .WR_LATENCY(WL), .RD_LATENCY(RL), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_addr(wa), .write_byte_en(be),
    .data_in(din), .read_enable(re), .read_addr(ra), .data_out(dout0), .read_valid(vld0));

  typedef struct { int t; logic [3:0] a; logic [3:0] be; logic [31:0] d; } wr_t;
  typedef struct { int due; logic [31:0] d; } rd_t;

  wr_t         wq[$];
  rd_t         sb1[$], sb0[$];
  logic [31:0] mmem [16];
  logic [31:0] last1 = '0, last0 = '0;
  int          e = 0;
  int          total = 0, bad = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, e, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic r, input logic [3:0] rad);
    we = w; wa = a; be = m; din = d; re = r; ra = rad;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  // Model the coming edge, take it, then check both instances.
  task automatic tick();
    int ne = e + 1;
    logic [31:0] x0, x1;
    if (rst_n) begin
      while (wq.size() > 0 && wq[0].t <= ne - WL) begin
        mmem[wq[0].a] = merge(mmem[wq[0].a], wq[0].be, wq[0].d);
        void'(wq.pop_front());
      end
      if (re) begin
        x0 = mmem[ra];
        x1 = x0;
        foreach (wq[i]) if (wq[i].a == ra) x1 = merge(x1, wq[i].be, wq[i].d);
        sb0.push_back('{ne + RL - 1, x0});
        sb1.push_back('{ne + RL - 1, x1});
      end
      if (we) wq.push_back('{ne, wa, be, din});
    end
    @(posedge clk);
    e++;
    #1;
    if (sb1.size() > 0 && sb1[0].due == e) begin
      chk("byp_valid", {31'b0, vld1}, 32'd1);
      chk("byp_data", dout1, sb1[0].d);
      last1 = sb1[0].d;
      void'(sb1.pop_front());
    end else begin
      chk("byp_novalid", {31'b0, vld1}, 32'd0);
      chk("byp_hold", dout1, last1);
    end
    if (sb0.size() > 0 && sb0[0].due == e) begin
      chk("nob_valid", {31'b0, vld0}, 32'd1);
      chk("nob_data", dout0, sb0[0].d);
      last0 = sb0[0].d;
      void'(sb0.pop_front());
    end else begin
      chk("nob_novalid", {31'b0, vld0}, 32'd0);
      chk("nob_hold", dout0, last0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Writes that already reached the array before reset survive it.
  task automatic assert_reset();
    rst_n = 1'b0;
    while (wq.size() > 0 && wq[0].t <= e - WL + 1) begin
      mmem[wq[0].a] = merge(mmem[wq[0].a], wq[0].be, wq[0].d);
      void'(wq.pop_front());
    end
    wq.delete();
    sb1.delete();
    sb0.delete();
    last1 = '0;
    last0 = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
    drive(1'b1, a, m, d, 1'b0, 4'h0);
    tick();
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mmem[i] = 'x;
    assert_reset();

    // Reset held with random traffic, then released idle.
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom));
      tick();
    end
    idle();
    rst_n = 1'b1;
    ticks(3);

    // Plain write then read after the write has committed.
    wr(4'h3, 4'hF, 32'hA5A5A5A5);
    idle(); ticks(3);
    rd(4'h3);
    idle(); ticks(3);

    // Byte-enable merge of two in-flight writes.
    wr(4'h5, 4'hF, 32'h0);
    idle(); ticks(3);
    wr(4'h5, 4'hF, 32'h11223344);
    wr(4'h5, 4'b0010, 32'h0000AA00);
    rd(4'h5);
    idle(); ticks(3);

    // Same-edge write/read returns old data; next-edge read depends on BYPASS.
    wr(4'h7, 4'hF, 32'h0);
    idle(); ticks(3);
    drive(1'b1, 4'h7, 4'hF, 32'hDEADBEEF, 1'b1, 4'h7);
    tick();
    rd(4'h7);
    idle(); ticks(4);

    // Fill, back-to-back readback, then a bubble.
    for (int i = 0; i < 16; i++) wr(4'(i), 4'hF, 32'(i));
    idle(); ticks(3);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(); ticks(3);
    rd(4'hA);
    idle(); tick();
    rd(4'hB);
    idle(); ticks(3);

    // Reset discards an in-flight write and an in-flight read.
    wr(4'h9, 4'hF, 32'h12345678);
    idle(); ticks(3);
    drive(1'b1, 4'h9, 4'hF, 32'hFFFFFFFF, 1'b1, 4'h9);
    tick();
    idle();
    assert_reset();
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    rd(4'h9);
    idle(); ticks(4);

    chk("sb_drained", 32'(sb1.size() + sb0.size() + wq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
